// File: rtl/jtkicker_pkg.sv
// Shared types for the kicker ROM arbiter.
// FSM states, grant selects and a width helper.
package jtkicker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_st_t;

  typedef enum logic {
    GNT_SCR = 1'b0,
    GNT_OBJ = 1'b1
  } gnt_t;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jtkicker_romarb_entry.sv
// One-word cache entry: tag, data, valid.
// Hit is combinational against the live address.
module jtkicker_romarb_entry #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [AW-1:0] wtag,
  input  logic [31:0]   wdata,
  output logic [31:0]   data,
  output logic          ok
);

  logic [AW-1:0] tag_q, tag_d;
  logic [31:0]   data_q, data_d;
  logic          vld_q, vld_d;

  // next entry contents on a fill
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    vld_d  = vld_q;
    if (we) begin
      tag_d  = wtag;
      data_d = wdata;
      vld_d  = 1'b1;
    end
  end

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data = data_q;
  assign ok   = cs & vld_q & (addr == tag_q);

endmodule

// File: rtl/jtkicker_romarb.sv
// Two-requester ROM arbiter with one-word caches.
// Alternating priority, no preemption, retry on timeout.
module jtkicker_romarb
  import jtkicker_pkg::*;
#(
  parameter int          SCR_AW   = 13,
  parameter int          OBJ_AW   = 14,
  parameter int          ROM_AW   = 15,
  parameter int unsigned OBJ_BASE = 32'h2000,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scr_cs,
  input  logic [SCR_AW-1:0] scr_addr,
  output logic [31:0]       scr_data,
  output logic              scr_ok,
  input  logic              obj_cs,
  input  logic [OBJ_AW-1:0] obj_addr,
  output logic [31:0]       obj_data,
  output logic              obj_ok,
  output logic              rom_cs,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              rom_ok
);

  localparam int AM = max2(SCR_AW, OBJ_AW);
  localparam int CW =
    (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  arb_st_t           st_q, st_d;
  gnt_t              gnt_q, gnt_d;
  gnt_t              last_q, last_d;
  gnt_t              sel;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [AM-1:0]     req_q, req_d;

  logic              scr_pend, obj_pend;
  logic              fill;
  logic [ROM_AW-1:0] scr_rom, obj_rom;

  assign scr_pend = scr_cs & ~scr_ok;
  assign obj_pend = obj_cs & ~obj_ok;
  assign fill     = (st_q == ST_WAIT) & rom_ok;

  assign scr_rom = ROM_AW'(scr_addr);
  assign obj_rom = ROM_AW'(obj_addr)
                 + ROM_AW'(OBJ_BASE);

  // pick a requester; on a tie the one not served last
  always_comb begin
    sel = GNT_SCR;
    if (scr_pend && obj_pend)
      sel = (last_q == GNT_OBJ) ? GNT_SCR : GNT_OBJ;
    else if (obj_pend)
      sel = GNT_OBJ;
  end

  // arbiter next-state and registered port outputs
  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    cs_d   = cs_q;
    addr_d = addr_q;
    req_d  = req_q;
    unique case (st_q)
      ST_IDLE: begin
        cs_d = 1'b0;
        if (scr_pend || obj_pend) begin
          st_d  = ST_ISSUE;
          gnt_d = sel;
          cs_d  = 1'b1;
          cnt_d = '0;
          if (sel == GNT_OBJ) begin
            addr_d = obj_rom;
            req_d  = AM'(obj_addr);
          end else begin
            addr_d = scr_rom;
            req_d  = AM'(scr_addr);
          end
        end
      end
      ST_ISSUE: begin
        st_d  = ST_WAIT;
        cnt_d = '0;
      end
      ST_WAIT: begin
        if (rom_ok) begin
          st_d   = ST_IDLE;
          cs_d   = 1'b0;
          last_d = gnt_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          st_d  = ST_ISSUE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d = ST_IDLE;
        cs_d = 1'b0;
      end
    endcase
  end

  // arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      gnt_q  <= GNT_SCR;
      last_q <= GNT_OBJ;
      cnt_q  <= '0;
      cs_q   <= 1'b0;
      addr_q <= '0;
      req_q  <= '0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      cs_q   <= cs_d;
      addr_q <= addr_d;
      req_q  <= req_d;
    end
  end

  assign rom_cs   = cs_q;
  assign rom_addr = addr_q;

  jtkicker_romarb_entry #(
    .AW (SCR_AW)
  ) u_scr (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (scr_cs),
    .addr  (scr_addr),
    .we    (fill & (gnt_q == GNT_SCR)),
    .wtag  (req_q[SCR_AW-1:0]),
    .wdata (rom_data),
    .data  (scr_data),
    .ok    (scr_ok)
  );

  jtkicker_romarb_entry #(
    .AW (OBJ_AW)
  ) u_obj (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (obj_cs),
    .addr  (obj_addr),
    .we    (fill & (gnt_q == GNT_OBJ)),
    .wtag  (req_q[OBJ_AW-1:0]),
    .wdata (rom_data),
    .data  (obj_data),
    .ok    (obj_ok)
  );

endmodule

// File: tb/tb_jtkicker_romarb.sv
// Bench for jtkicker_romarb: transaction-level model,
// per-cycle compare, directed pins and random traffic.
module tb_jtkicker_romarb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scr_cs, obj_cs;
  logic [12:0] scr_addr;
  logic [13:0] obj_addr;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok;
  logic        rom_cs;
  logic [14:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtkicker_romarb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scr_cs   (scr_cs),
    .scr_addr (scr_addr),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  // model: cache per requester and one fetch in flight
  bit          mv[2];
  int unsigned mtag[2];
  logic [31:0] mdat[2];
  bit          m_busy;
  int          m_who, m_age, m_last;
  int unsigned m_req;
  logic [14:0] m_addr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mtag[i] = 0; mdat[i] = '0;
    end
    m_busy = 0; m_who = 0; m_age = 0;
    m_last = 1; m_req = 0; m_addr = '0;
  endtask

  function automatic bit mhit(int w);
    if (w == 0)
      return scr_cs && mv[0] && mtag[0] == scr_addr;
    return obj_cs && mv[1] && mtag[1] == obj_addr;
  endfunction

  // one clock edge of the model, using current inputs
  task automatic mstep();
    bit p0, p1;
    if (!rst_n) begin
      mreset();
    end else if (m_busy) begin
      if (m_age == 0) begin
        m_age = 1;
      end else if (rom_ok) begin
        mv[m_who] = 1;
        mtag[m_who] = m_req;
        mdat[m_who] = rom_data;
        m_last = m_who;
        m_busy = 0;
      end else if (m_age == 255) begin
        m_age = 0;
      end else begin
        m_age++;
      end
    end else begin
      p0 = scr_cs && !mhit(0);
      p1 = obj_cs && !mhit(1);
      if (p0 || p1) begin
        if (p0 && p1) m_who = (m_last == 1) ? 0 : 1;
        else m_who = p0 ? 0 : 1;
        m_busy = 1;
        m_age = 0;
        if (m_who == 0) begin
          m_req = scr_addr;
          m_addr = 15'(scr_addr);
        end else begin
          m_req = obj_addr;
          m_addr = 15'((obj_addr + 32'h2000) % 32768);
        end
      end
    end
  endtask

  // compare now, then advance one clock
  task automatic tick();
    #1;
    chk("scr_ok", 32'(scr_ok), 32'(mhit(0)));
    chk("obj_ok", 32'(obj_ok), 32'(mhit(1)));
    chk("scr_data", scr_data, mdat[0]);
    chk("obj_data", obj_data, mdat[1]);
    chk("rom_cs", 32'(rom_cs), 32'(m_busy));
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    @(posedge clk);
    mstep();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mreset();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  logic [14:0] a0;

  initial begin
    rst_n = 1'b0;
    scr_cs = 1'b1; obj_cs = 1'b1;
    scr_addr = '0; obj_addr = '0;
    rom_data = '0; rom_ok = 1'b0;
    mreset();
    @(negedge clk);
    tick();
    chk("rst_rom_cs", 32'(rom_cs), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_scr_ok", 32'(scr_ok), 0);
    chk("rst_obj_ok", 32'(obj_ok), 0);
    chk("rst_scr_data", scr_data, 0);
    chk("rst_obj_data", obj_data, 0);
    scr_cs = 1'b0; obj_cs = 1'b0;
    rst_n = 1'b1;
    tick();

    // lone scroll miss, rom_ok three cycles after issue
    scr_cs = 1'b1; scr_addr = 13'h0123;
    tick();
    chk("d1_rom_cs", 32'(rom_cs), 1);
    chk("d1_rom_addr", 32'(rom_addr), 32'h0123);
    tick();
    tick();
    rom_ok = 1'b1; rom_data = 32'hDEADBEEF;
    tick();
    chk("d1_scr_ok", 32'(scr_ok), 1);
    chk("d1_scr_data", scr_data, 32'hDEADBEEF);
    rom_ok = 1'b0;
    tick();
    chk("d1_hit_no_cs", 32'(rom_cs), 0);

    // simultaneous misses, rom_ok held high throughout
    do_reset();
    scr_cs = 1'b1; scr_addr = 13'h0010;
    obj_cs = 1'b1; obj_addr = 14'h0020;
    tick();
    chk("d2_scr_first", 32'(rom_addr), 32'h0010);
    rom_ok = 1'b1; rom_data = 32'h11110000;
    tick();
    chk("d2_issue_ign", 32'(scr_ok), 0);
    chk("d2_wait_cs", 32'(rom_cs), 1);
    tick();
    chk("d2_scr_ok", 32'(scr_ok), 1);
    chk("d2_scr_data", scr_data, 32'h11110000);
    rom_data = 32'h22220000;
    tick();
    chk("d2_obj_addr", 32'(rom_addr), 32'h2020);
    tick();
    tick();
    chk("d2_obj_ok", 32'(obj_ok), 1);
    chk("d2_obj_data", obj_data, 32'h22220000);
    scr_addr = 13'h0011; rom_data = 32'h33330000;
    repeat (3) tick();
    scr_addr = 13'h0012; obj_addr = 14'h0022;
    tick();
    chk("d2_obj_first", 32'(rom_addr), 32'h2022);
    tick();
    tick();
    tick();
    chk("d2_scr_next", 32'(rom_addr), 32'h0012);
    tick();
    tick();
    rom_ok = 1'b0;
    obj_cs = 1'b0;

    // address moves while waiting
    scr_addr = 13'h0005;
    tick();
    tick();
    scr_addr = 13'h0006;
    rom_ok = 1'b1; rom_data = 32'h55550005;
    tick();
    chk("d3_stale_ok", 32'(scr_ok), 0);
    chk("d3_idle_cs", 32'(rom_cs), 0);
    rom_ok = 1'b0;
    tick();
    chk("d3_refetch", 32'(rom_addr), 32'h0006);
    rom_ok = 1'b1; rom_data = 32'h66660006;
    tick();
    tick();
    chk("d3_ok", 32'(scr_ok), 1);
    chk("d3_data", scr_data, 32'h66660006);
    rom_ok = 1'b0;

    // timeout: re-issue at cycle 256 ignores rom_ok
    scr_addr = 13'h0100;
    tick();
    a0 = rom_addr;
    for (int c = 0; c <= 300; c++) begin
      rom_ok = (c == 256) || (c == 300);
      rom_data = 32'h12345678;
      if (c == 256) begin
        chk("d4_reissue_cs", 32'(rom_cs), 1);
        chk("d4_reissue_adr", 32'(rom_addr), 32'(a0));
      end
      if (c == 257)
        chk("d4_ok_ignored", 32'(scr_ok), 0);
      tick();
    end
    chk("d4_done_ok", 32'(scr_ok), 1);
    chk("d4_done_data", scr_data, 32'h12345678);
    rom_ok = 1'b0;

    // reset pulse during a fetch
    scr_addr = 13'h0040;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    mreset();
    #1;
    chk("d5_async_cs", 32'(rom_cs), 0);
    chk("d5_async_ok", 32'(scr_ok), 0);
    chk("d5_async_data", scr_data, 0);
    @(negedge clk);
    scr_cs = 1'b0; obj_cs = 1'b0;
    rom_ok = 1'b1; rom_data = 32'hBAD0BAD0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("d5_no_fill", scr_data, 0);
    chk("d5_no_fill_o", obj_data, 0);
    rom_ok = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 8) scr_cs = 1'b1;
      else scr_cs = 1'b0;
      if ($urandom_range(0, 9) < 8) obj_cs = 1'b1;
      else obj_cs = 1'b0;
      if ($urandom_range(0, 3) == 0)
        scr_addr = 13'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        obj_addr = 14'($urandom_range(0, 7));
      rom_ok = ($urandom_range(0, 9) < 4);
      rom_data = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtkicker_romarb.md
JTKICKER_ROMARB -- requirements
Module: jtkicker_romarb

Interface
REQ-001 Parameter SCR_AW, default 13: scroll-layer ROM word-address width.
REQ-002 Parameter OBJ_AW, default 14: object-layer ROM word-address width.
REQ-003 Parameter ROM_AW, default 15: shared ROM port address width; SHALL be at least max(SCR_AW,OBJ_AW)+1.
REQ-004 Parameter OBJ_BASE, default 15'h2000: word offset added to obj_addr on the shared port.
REQ-005 Parameter TIMEOUT, default 255: wait cycles before a request is re-issued.
REQ-006 clk  in  1  system clock (48 MHz); sole clock, all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 scr_cs  in  1  scroll fetch request.
REQ-009 scr_addr  in  SCR_AW  scroll fetch word address.
REQ-010 scr_data  out  32  scroll fetch data.
REQ-011 scr_ok  out  1  scr_data valid for the current scr_addr.
REQ-012 obj_cs, obj_addr[OBJ_AW], obj_data[32], obj_ok: object requester; same directions and meanings as REQ-008..011.
REQ-013 rom_cs  out  1  shared-port request.
REQ-014 rom_addr  out  ROM_AW  shared-port word address.
REQ-015 rom_data  in  32  shared-port data.
REQ-016 rom_ok  in  1  shared-port data valid; may remain high from a previous address.

Function
REQ-017 Each requester SHALL own a cache entry: tag (address), 32-bit data, valid bit.
REQ-018 x_ok SHALL equal x_cs AND valid AND (x_addr==tag), combinationally; x_data SHALL always drive the cached data.
REQ-019 A requester is pending when x_cs=1 and x_ok=0 (a miss).
REQ-020 FSM states: IDLE, ISSUE, WAIT.
REQ-021 IDLE: no pending requester -> stay; one pending -> grant it, go to ISSUE; both pending -> grant the one not granted last (last-grant bit, reset value = obj, so scroll wins first), go to ISSUE.
REQ-022 ISSUE (exactly 1 cycle): rom_cs=1, rom_addr latched from the granted address (scroll: zero-extended scr_addr; object: obj_addr+OBJ_BASE, ROM_AW-bit wrap), rom_ok ignored; -> WAIT.
REQ-023 WAIT: rom_cs=1, rom_addr held; on rom_ok=1, write rom_data, latched address and valid=1 into the granted cache, clear valid of nothing else, update last-grant, -> IDLE; x_ok thus rises on the cycle after rom_ok if x_addr is unchanged.
REQ-024 rom_cs SHALL be 0 in IDLE; rom_addr SHALL hold its last value in IDLE.
REQ-025 Address change during ISSUE/WAIT: the fetch SHALL complete for the latched address (cache filled, ok stays 0 because tag mismatches); the new address is served on a later grant; no abort.
REQ-026 Requester dropping x_cs mid-fetch: fetch SHALL still complete and fill the cache.
REQ-027 Wait counter (8 bits minimum) SHALL clear in ISSUE and increment in WAIT; on reaching TIMEOUT without rom_ok, return to ISSUE with the same grant and address (rom_cs drops for no cycle; counter restarts).
REQ-028 Grants are never preempted; a scroll miss arriving during an object fetch waits for it to finish.
REQ-029 Worst-case scroll miss latency with a 4-cycle rom_ok SHALL be ≤ 12 cycles (one object fetch plus own fetch).

Reset
REQ-030 On rst_n=0: state=IDLE, rom_cs=0, rom_addr=0, both valid bits=0, tags=0, cached data=0, last-grant=obj, counter=0; hence scr_ok=obj_ok=0, scr_data=obj_data=0.
REQ-031 Reset mid-fetch SHALL discard the fetch; no cache entry is written by a rom_ok arriving after reset release unless a new ISSUE has occurred.

Structure
REQ-032 FSM state encoding and the grant-select constants (SCR=0, OBJ=1) SHALL live in shared package jtkicker_pkg.
REQ-033 One sub-module, jtkicker_romarb_entry (tag/data/valid register plus hit compare), SHALL be instantiated twice.

Verification
REQ-034 Scroll miss alone, scr_addr=13'h0123, rom_ok 3 cycles after ISSUE, rom_data=32'hDEADBEEF -> rom_addr=15'h0123, scr_ok=1 with scr_data=DEADBEEF 1 cycle later; repeated scr_addr gives hit with no rom_cs.
REQ-035 Simultaneous misses after reset (scr 13'h0010, obj 14'h0020) -> scroll fetch first at 15'h0010, then object at 15'h2020; next simultaneous misses -> object first.
REQ-036 rom_ok held high from the previous fetch -> ignored in ISSUE, data captured only on the WAIT cycle.
REQ-037 rom_ok withheld 300 cycles -> re-ISSUE at cycle 256 with the same rom_addr; completes when rom_ok finally arrives.
REQ-038 scr_addr changes from 13'h0005 to 13'h0006 during WAIT -> entry filled with tag 0005, scr_ok=0, second fetch at 15'h0006 follows.
REQ-039 rst_n pulsed low during WAIT -> all outputs at reset values asynchronously; a stale rom_ok fills nothing.
